// File: rtl/coin_pkg.sv
// Shared coin-table definitions: entry layout, screen bounds, colours and renderer states.
// Used by both the coin renderer and the collision/point logic.
package coin_pkg;

  localparam int NUM_COINS  = 10;
  localparam int COIN_W     = 4;
  localparam int COIN_H     = 4;

  localparam int EXISTS_BIT = 15;
  localparam int X_MSB      = 14;
  localparam int X_LSB      = 7;
  localparam int Y_MSB      = 6;
  localparam int Y_LSB      = 0;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  localparam logic [2:0] COIN_COLOUR = 3'b110;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LATCH,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } render_state_e;

  typedef struct packed {
    logic       exists;
    logic [7:0] x;
    logic [6:0] y;
  } coin_entry_t;

  function automatic coin_entry_t unpack_entry(input logic [15:0] word);
    coin_entry_t e;
    e.exists = word[EXISTS_BIT];
    e.x      = word[X_MSB:X_LSB];
    e.y      = word[Y_MSB:Y_LSB];
    return e;
  endfunction

endpackage

// File: rtl/coin_sprite_walker.sv
// Steps (dx,dy) across one coin sprite in raster order and presents the pixel it moves to:
// origin sum, off-screen clip flag, and a flag marking the sprite's final pixel.
module coin_sprite_walker #(
  parameter int COIN_W = coin_pkg::COIN_W,
  parameter int COIN_H = coin_pkg::COIN_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       init,
  input  logic       step,
  input  logic [7:0] org_x,
  input  logic [6:0] org_y,
  output logic [7:0] nxt_x,
  output logic [6:0] nxt_y,
  output logic       nxt_clip,
  output logic       last
);
  import coin_pkg::*;

  localparam int DXW = (COIN_W > 1) ? $clog2(COIN_W) : 1;
  localparam int DYW = (COIN_H > 1) ? $clog2(COIN_H) : 1;
  localparam logic [DXW-1:0] DX_MAX = DXW'(COIN_W - 1);
  localparam logic [DYW-1:0] DY_MAX = DYW'(COIN_H - 1);

  logic [DXW-1:0] dx_q, dx_d;
  logic [DYW-1:0] dy_q, dy_d;
  logic [8:0]     sum_x;
  logic [7:0]     sum_y;

  // dx_q/dy_q always name the pixel currently held at the renderer outputs.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (init) begin
      dx_d = '0;
      dy_d = '0;
    end else if (step) begin
      if (dx_q == DX_MAX) begin
        dx_d = '0;
        dy_d = dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  // Sums are one bit wider than the screen coordinates so overflow is clipped, never wrapped.
  assign sum_x    = {1'b0, org_x} + 9'(dx_d);
  assign sum_y    = {1'b0, org_y} + 8'(dy_d);
  assign nxt_clip = (sum_x >= 9'(SCREEN_W)) || (sum_y >= 8'(SCREEN_H));
  assign nxt_x    = sum_x[7:0];
  assign nxt_y    = sum_y[6:0];
  assign last     = (dx_q == DX_MAX) && (dy_q == DY_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/coin_renderer.sv
// Scans the coin table once per start pulse and streams each live coin's sprite as pixel writes.
// Define COIN_RENDER_ERASE_EN to also draw empty entries in the background colour.
module coin_renderer #(
  parameter int         NUM_COINS   = coin_pkg::NUM_COINS,
  parameter int         COIN_W      = coin_pkg::COIN_W,
  parameter int         COIN_H      = coin_pkg::COIN_H,
  parameter logic [2:0] COIN_COLOUR = coin_pkg::COIN_COLOUR,
  parameter logic [2:0] BG_COLOUR   = coin_pkg::BG_COLOUR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  mem_addr,
  input  logic [15:0] mem_q,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_valid,
  input  logic        pix_ready
);
  import coin_pkg::*;

`ifdef COIN_RENDER_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif

  render_state_e state_q, state_d;
  logic [4:0]    index_q, index_d;
  logic [4:0]    mem_addr_q, mem_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pix_valid_q, pix_valid_d;
  logic [7:0]    pix_x_q, pix_x_d;
  logic [6:0]    pix_y_q, pix_y_d;
  logic [2:0]    pix_colour_q, pix_colour_d;
  logic          exists_q, exists_d;
  logic [7:0]    cx_q, cx_d;
  logic [6:0]    cy_q, cy_d;

  coin_entry_t   ent;
  logic          adv;
  logic          w_init, w_step, w_clip, w_last;
  logic [7:0]    w_org_x, w_nxt_x;
  logic [6:0]    w_org_y, w_nxt_y;

  assign ent = unpack_entry(mem_q);

  // A held pixel advances on handshake; a clipped slot (valid low) advances unconditionally.
  assign adv     = !pix_valid_q || pix_ready;
  assign w_init  = (state_q == ST_LATCH);
  assign w_step  = (state_q == ST_DRAW) && adv && !w_last;
  assign w_org_x = w_init ? ent.x : cx_q;
  assign w_org_y = w_init ? ent.y : cy_q;

  coin_sprite_walker #(
    .COIN_W (COIN_W),
    .COIN_H (COIN_H)
  ) u_walker (
    .clk      (clk),
    .resetn   (resetn),
    .init     (w_init),
    .step     (w_step),
    .org_x    (w_org_x),
    .org_y    (w_org_y),
    .nxt_x    (w_nxt_x),
    .nxt_y    (w_nxt_y),
    .nxt_clip (w_clip),
    .last     (w_last)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    mem_addr_d   = mem_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_colour_d = pix_colour_q;
    exists_d     = exists_q;
    cx_d         = cx_q;
    cy_d         = cy_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          index_d    = '0;
          mem_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_LATCH;
      ST_LATCH: begin
        exists_d = ent.exists;
        cx_d     = ent.x;
        cy_d     = ent.y;
        if (ent.exists || ERASE_EN) begin
          state_d     = ST_DRAW;
          pix_valid_d = !w_clip;
          // Clipped slots keep the old payload so a wrapped coordinate never shows.
          if (!w_clip) begin
            pix_x_d      = w_nxt_x;
            pix_y_d      = w_nxt_y;
            pix_colour_d = ent.exists ? COIN_COLOUR : BG_COLOUR;
          end
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_DRAW: begin
        if (adv) begin
          if (w_last) begin
            state_d     = ST_NEXT;
            pix_valid_d = 1'b0;
          end else begin
            pix_valid_d = !w_clip;
            if (!w_clip) begin
              pix_x_d      = w_nxt_x;
              pix_y_d      = w_nxt_y;
              pix_colour_d = exists_q ? COIN_COLOUR : BG_COLOUR;
            end
          end
        end
      end
      ST_NEXT: begin
        if (index_q == 5'(NUM_COINS - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_FETCH;
          index_d    = index_q + 5'd1;
          mem_addr_d = index_q + 5'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      exists_q     <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_colour_q <= pix_colour_d;
      exists_q     <= exists_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_addr   = mem_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_colour = pix_colour_q;

endmodule

// File: tb/tb_coin_renderer.sv
// Directed bench for coin_renderer: registered-read table model, pixel capture and stall checks.
module tb_coin_renderer;

`ifdef COIN_RENDER_ERASE_EN
  localparam int EXTRA = 144;
  localparam int LAT1  = 201;
  localparam int LAT0  = 201;
  localparam int NV0   = 160;
`else
  localparam int EXTRA = 0;
  localparam int LAT1  = 57;
  localparam int LAT0  = 41;
  localparam int NV0   = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b1;
  logic [15:0] mem_q = '0;
  logic        busy, done, pix_valid;
  logic [4:0]  mem_addr;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;

  logic [15:0] coin_tab [0:31];
  logic [17:0] pq[$];
  int          sq[$];
  int          cyc = 0;
  int          t0 = 0;
  int          nvalid = 0;
  int          nvec = 0;
  int          nfail = 0;
  bit          bp_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_pay = '0;
  int          lat;

  coin_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle registered-read RAM.
  initial forever begin
    @(posedge clk);
    mem_q <= coin_tab[mem_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready: held high, or 1 cycle on / 2 off when bp_mode is set.
  initial begin : ready_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      pix_ready = bp_mode ? (ph == 0) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (resetn) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, pix_valid}, 32'd1);
        chk("stall_payload", {14'd0, pix_x, pix_y, pix_colour}, {14'd0, prev_pay});
      end
      if (pix_valid) nvalid++;
      if (pix_valid && pix_ready) begin
        pq.push_back({pix_x, pix_y, pix_colour});
        sq.push_back(cyc - t0 + 1);
      end
    end
    prev_stall = resetn && pix_valid && !pix_ready;
    prev_pay   = {pix_x, pix_y, pix_colour};
  end

  task automatic clear_tab();
    for (int i = 0; i < 32; i++) coin_tab[i] = 16'h0000;
  endtask

  // lat = cycle (counted from the start edge) in which done is seen.
  task automatic run_pass(input int extra_at, output int lat_o);
    pq.delete();
    sq.delete();
    nvalid = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("addr_after_start", {27'd0, mem_addr}, 32'd0);
    lat_o = 1;
    while (!done && lat_o < 3000) begin
      @(negedge clk);
      lat_o++;
      start = (lat_o == extra_at);
    end
    start = 1'b0;
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic chk_sprite(input string tag, input int base, input int x0, input int y0,
                            input logic [2:0] col);
    logic [17:0] e;
    logic [17:0] o;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        e = {8'(x0 + dx), 7'(y0 + dy), col};
        o = (base + dy * 4 + dx < pq.size()) ? pq[base + dy * 4 + dx] : 18'h3ffff;
        chk(tag, {14'd0, o}, {14'd0, e});
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
    chk({tag, "_done"},   {31'd0, done}, 32'd0);
    chk({tag, "_valid"},  {31'd0, pix_valid}, 32'd0);
    chk({tag, "_x"},      {24'd0, pix_x}, 32'd0);
    chk({tag, "_y"},      {25'd0, pix_y}, 32'd0);
    chk({tag, "_colour"}, {29'd0, pix_colour}, 32'd0);
    chk({tag, "_addr"},   {27'd0, mem_addr}, 32'd0);
  endtask

  initial begin : main
    bit found;
    clear_tab();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;

    // Single live coin at (10,20).
    coin_tab[0] = {1'b1, 8'd10, 7'd20};
    run_pass(0, lat);
    chk("single_latency", lat, LAT1);
    chk("single_count", pq.size(), 16 + EXTRA);
    chk_sprite("single_pix", 0, 10, 20, 3'b110);
    chk("single_first_cycle", (sq.size() > 0) ? sq[0] : -1, 4);
    chk("single_last_cycle", (sq.size() > 15) ? sq[15] : -1, 19);

    // Start pulsed mid-pass must not restart it.
    run_pass(10, lat);
    chk("ignored_start_latency", lat, LAT1);
    chk("ignored_start_count", pq.size(), 16 + EXTRA);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", {31'd0, busy}, 32'd0);

    // Backpressure 1 on / 2 off.
    bp_mode = 1'b1;
    run_pass(0, lat);
    bp_mode = 1'b0;
    chk("bp_count", pq.size(), 16 + EXTRA);
    chk_sprite("bp_pix", 0, 10, 20, 3'b110);

    // Clipping at the bottom-right corner.
    coin_tab[0] = {1'b1, 8'd158, 7'd118};
    run_pass(0, lat);
    chk("clip_latency", lat, LAT1);
    chk("clip_count", pq.size(), 4 + EXTRA);
    chk("clip_p0", {14'd0, (pq.size() > 0) ? pq[0] : 18'h3ffff}, {14'd0, 8'd158, 7'd118, 3'b110});
    chk("clip_p1", {14'd0, (pq.size() > 1) ? pq[1] : 18'h3ffff}, {14'd0, 8'd159, 7'd118, 3'b110});
    chk("clip_p2", {14'd0, (pq.size() > 2) ? pq[2] : 18'h3ffff}, {14'd0, 8'd158, 7'd119, 3'b110});
    chk("clip_p3", {14'd0, (pq.size() > 3) ? pq[3] : 18'h3ffff}, {14'd0, 8'd159, 7'd119, 3'b110});

    // All entries empty.
    clear_tab();
    run_pass(0, lat);
    chk("empty_latency", lat, LAT0);
    chk("empty_valid_cycles", nvalid, NV0);

    // Eaten coin at entry 3.
    coin_tab[3] = {1'b0, 8'd40, 7'd40};
    run_pass(0, lat);
`ifdef COIN_RENDER_ERASE_EN
    chk("erase_count", pq.size(), 160);
    chk_sprite("erase_pix", 48, 40, 40, 3'b000);
`else
    chk("erase_count", pq.size(), 0);
    chk("erase_valid_cycles", nvalid, 0);
`endif

    // Reset while drawing coin 2.
    clear_tab();
    coin_tab[2] = {1'b1, 8'd50, 7'd60};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (pix_valid && mem_addr == 5'd2) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_coin2", {31'd0, found}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("midreset_no_done", {31'd0, done}, 32'd0);
    chk("midreset_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
